mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_DSTREAK, default 4: maximum consecutive data grants while a fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum busy cycles without MemAck_i before abort.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk_i  in  1  clock, rising edge; rst_n_i  in  1  async active-low reset.
REQ-004 SHALL have ports: IReq_i  in  1  fetch request, held until IValid_o; IAddr_i  in  32  fetch address.
REQ-005 SHALL have ports: IRdata_o  out  32  fetched word; IValid_o  out  1  one-cycle fetch-done pulse.
REQ-006 SHALL have ports: DReq_i  in  1  data request, held until DValid_o; DWe_i  in  1  write when 1; DAddr_i  in  32; DWdata_i  in  32.
REQ-007 SHALL have ports: DRdata_o  out  32  load data; DValid_o  out  1  one-cycle data-done pulse.
REQ-008 SHALL have ports: MemReq_o  out  1; MemWe_o  out  1; MemAddr_o  out  32; MemWdata_o  out  32; MemRdata_i  in  32; MemAck_i  in  1  one-cycle completion.
REQ-009 SHALL have ports: StallF_o  out  1; StallM_o  out  1  stall requests to hazard unit; ErrTimeout_o  out  1  sticky error.

Function
REQ-010 SHALL implement FSM states IDLE, IBUSY, DBUSY.
REQ-011 IDLE: DReq_i only -> DBUSY; IReq_i only -> IBUSY; neither -> stay IDLE.
REQ-012 IDLE, both requesting: DBUSY unless streak==MAX_DSTREAK, then IBUSY.
REQ-013 On grant SHALL latch address, DWe_i (0 for fetch), DWdata_i (0 for fetch) into registers driving MemAddr_o/MemWe_o/MemWdata_o.
REQ-014 MemReq_o SHALL be registered, 1 exactly while in IBUSY/DBUSY; Mem* outputs stable until ack.
REQ-015 BUSY + MemAck_i: SHALL register MemRdata_i into IRdata_o/DRdata_o, pulse matching Valid_o next cycle, return to IDLE.
REQ-016 Writes SHALL also pulse DValid_o; DRdata_o updated with MemRdata_i regardless.
REQ-017 SHALL insert one IDLE cycle between transactions; no regrant in the ack cycle.
REQ-018 MemAck_i in IDLE SHALL be ignored.
REQ-019 Streak counter (3 bits min): +1 on D grant with IReq_i high; cleared on I grant or on D grant with IReq_i low; saturates at MAX_DSTREAK.
REQ-020 Busy counter SHALL clear on grant, +1 each BUSY cycle without ack; reaching TIMEOUT -> return to IDLE, pulse matching Valid_o, rdata output 0, set ErrTimeout_o.
REQ-021 ErrTimeout_o SHALL stay 1 until reset.
REQ-022 StallF_o = IReq_i & ~IValid_o; StallM_o = DReq_i & ~DValid_o (combinational).
REQ-023 Requester dropping Req_i mid-transaction SHALL NOT abort it; Valid_o still pulses.
REQ-024 Req_i high in cycle after Valid_o SHALL be treated as a new request.
REQ-025 Latency: grant edge -> MemReq_o high; ack cycle N -> Valid_o high cycle N+1; fetch with 1-cycle ack memory = 3 cycles request-to-valid.

Reset
REQ-026 rst_n_i low SHALL immediately force IDLE, MemReq_o=0, MemWe_o=0, MemAddr_o=0, MemWdata_o=0, IValid_o=0, DValid_o=0, IRdata_o=0, DRdata_o=0, ErrTimeout_o=0, counters=0.
REQ-027 Reset asserted mid-transaction SHALL abandon it; no Valid_o pulse after release; later ack ignored in IDLE.
REQ-028 First grant SHALL occur on the first rising edge after rst_n_i deasserts.

Verification
REQ-029 Fetch only, IAddr_i=0x100, ack 2 cycles after MemReq_o, MemRdata_i=0x00500093 -> IRdata_o=0x00500093, IValid_o pulse, StallF_o 1 until pulse.
REQ-030 IReq_i and DReq_i together (DWe_i=1, DAddr_i=0x2000, DWdata_i=0xDEADBEEF) -> data first, MemWe_o=1, DValid_o, one IDLE cycle, then fetch.
REQ-031 IReq_i held, DReq_i re-asserted after each DValid_o -> exactly 4 D grants then I grant; streak cleared.
REQ-032 Grant, no ack -> after 15 busy cycles Valid_o pulses with data 0, ErrTimeout_o=1 sticky, MemReq_o=0.
REQ-033 rst_n_i low during DBUSY -> MemReq_o 0 same cycle, no DValid_o, ack after release ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and data access share one memory port.
// Data wins ties until MAX_DSTREAK back-to-back data grants have starved a waiting fetch.
module mem_port_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        IReq_i,
  input  logic [31:0] IAddr_i,
  output logic [31:0] IRdata_o,
  output logic        IValid_o,
  input  logic        DReq_i,
  input  logic        DWe_i,
  input  logic [31:0] DAddr_i,
  input  logic [31:0] DWdata_i,
  output logic [31:0] DRdata_o,
  output logic        DValid_o,
  output logic        MemReq_o,
  output logic        MemWe_o,
  output logic [31:0] MemAddr_o,
  output logic [31:0] MemWdata_o,
  input  logic [31:0] MemRdata_i,
  input  logic        MemAck_i,
  output logic        StallF_o,
  output logic        StallM_o,
  output logic        ErrTimeout_o
);

  localparam int SW = ($clog2(MAX_DSTREAK + 1) > 3) ? $clog2(MAX_DSTREAK + 1) : 3;
  localparam int BW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [BW-1:0] BUSY_LIMIT = BW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

  state_t        state_reg, state_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [31:0]   mem_addr_reg, mem_addr_next;
  logic [31:0]   mem_wdata_reg, mem_wdata_next;
  logic [31:0]   i_rdata_reg, i_rdata_next;
  logic [31:0]   d_rdata_reg, d_rdata_next;
  logic          i_valid_reg, i_valid_next;
  logic          d_valid_reg, d_valid_next;
  logic          err_reg, err_next;
  logic [SW-1:0] streak_reg, streak_next;
  logic [BW-1:0] busy_reg, busy_next;
  logic [BW-1:0] busy_inc;
  logic          grant_d, grant_i;

  assign busy_inc = busy_reg + BW'(1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      i_rdata_reg   <= '0;
      d_rdata_reg   <= '0;
      i_valid_reg   <= 1'b0;
      d_valid_reg   <= 1'b0;
      err_reg       <= 1'b0;
      streak_reg    <= '0;
      busy_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      i_valid_reg   <= i_valid_next;
      d_valid_reg   <= d_valid_next;
      err_reg       <= err_next;
      streak_reg    <= streak_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    i_valid_next   = 1'b0;
    d_valid_next   = 1'b0;
    err_next       = err_reg;
    streak_next    = streak_reg;
    busy_next      = busy_reg;
    grant_d        = 1'b0;
    grant_i        = 1'b0;

    case (state_reg)
      IDLE: begin
        // The cycle carrying a Valid pulse never grants: a requester still holding
        // its request then must not be served twice.
        if (!(i_valid_reg || d_valid_reg)) begin
          grant_d = DReq_i && !(IReq_i && (streak_reg == STREAK_MAX));
          grant_i = IReq_i && !grant_d;
        end
        if (grant_d) begin
          state_next     = DBUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = DWe_i;
          mem_addr_next  = DAddr_i;
          mem_wdata_next = DWdata_i;
          busy_next      = '0;
          if (!IReq_i)
            streak_next = '0;
          else if (streak_reg != STREAK_MAX)
            streak_next = streak_reg + SW'(1);
        end else if (grant_i) begin
          state_next     = IBUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = IAddr_i;
          mem_wdata_next = '0;
          busy_next      = '0;
          streak_next    = '0;
        end
      end
      IBUSY, DBUSY: begin
        if (MemAck_i || (busy_inc == BUSY_LIMIT)) begin
          // An abort returns zero data but still completes the handshake.
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (state_reg == IBUSY) begin
            i_rdata_next = MemAck_i ? MemRdata_i : 32'h0;
            i_valid_next = 1'b1;
          end else begin
            d_rdata_next = MemAck_i ? MemRdata_i : 32'h0;
            d_valid_next = 1'b1;
          end
          if (!MemAck_i)
            err_next = 1'b1;
        end else begin
          busy_next = busy_inc;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  assign MemReq_o     = mem_req_reg;
  assign MemWe_o      = mem_we_reg;
  assign MemAddr_o    = mem_addr_reg;
  assign MemWdata_o   = mem_wdata_reg;
  assign IRdata_o     = i_rdata_reg;
  assign DRdata_o     = d_rdata_reg;
  assign IValid_o     = i_valid_reg;
  assign DValid_o     = d_valid_reg;
  assign ErrTimeout_o = err_reg;
  assign StallF_o     = IReq_i & ~i_valid_reg;
  assign StallM_o     = DReq_i & ~d_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, scripted memory responder.
module tb_mem_port_arbiter;

  localparam int MAX_DSTREAK = 4;
  localparam int TIMEOUT     = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IReq_i, DReq_i, DWe_i, MemAck_i;
  logic [31:0] IAddr_i, DAddr_i, DWdata_i, MemRdata_i;
  logic [31:0] IRdata_o, DRdata_o, MemAddr_o, MemWdata_o;
  logic        IValid_o, DValid_o, MemReq_o, MemWe_o, StallF_o, StallM_o, ErrTimeout_o;

  int n_checks = 0;
  int n_errors = 0;

  // memory responder controls
  int ack_delay = 0;
  bit stray_ack = 1'b0;

  // transaction-level model: owner 0 = none, 1 = fetch, 2 = data
  int          m_owner, m_age, m_streak;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit          m_we, m_ivalid, m_dvalid, m_err;

  mem_port_arbiter #(.MAX_DSTREAK(MAX_DSTREAK), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .IReq_i(IReq_i), .IAddr_i(IAddr_i), .IRdata_o(IRdata_o), .IValid_o(IValid_o),
    .DReq_i(DReq_i), .DWe_i(DWe_i), .DAddr_i(DAddr_i), .DWdata_i(DWdata_i),
    .DRdata_o(DRdata_o), .DValid_o(DValid_o),
    .MemReq_o(MemReq_o), .MemWe_o(MemWe_o), .MemAddr_o(MemAddr_o), .MemWdata_o(MemWdata_o),
    .MemRdata_i(MemRdata_i), .MemAck_i(MemAck_i),
    .StallF_o(StallF_o), .StallM_o(StallM_o), .ErrTimeout_o(ErrTimeout_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_for(input logic [31:0] addr);
    if (addr == 32'h100) return 32'h00500093;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no response within cycle budget at %0t", name, $time);
  endtask

  task automatic m_reset();
    m_owner = 0; m_age = 0; m_streak = 0;
    m_addr = 0; m_wdata = 0; m_we = 0;
    m_irdata = 0; m_drdata = 0; m_ivalid = 0; m_dvalid = 0; m_err = 0;
  endtask

  task automatic m_finish(input logic [31:0] data);
    if (m_owner == 1) begin m_irdata = data; m_ivalid = 1; end
    else begin m_drdata = data; m_dvalid = 1; end
    m_owner = 0;
  endtask

  task automatic model_step();
    bit cool;
    if (!rst_n) begin
      m_reset();
      return;
    end
    cool = m_ivalid | m_dvalid;
    m_ivalid = 0;
    m_dvalid = 0;
    if (m_owner != 0) begin
      m_age++;
      if (MemAck_i) m_finish(MemRdata_i);
      else if (m_age >= TIMEOUT) begin m_finish(32'h0); m_err = 1; end
    end else if (!cool && (IReq_i || DReq_i)) begin
      m_age = 0;
      if (DReq_i && !(IReq_i && m_streak >= MAX_DSTREAK)) begin
        m_owner = 2; m_addr = DAddr_i; m_we = DWe_i; m_wdata = DWdata_i;
        m_streak = IReq_i ? ((m_streak + 1 > MAX_DSTREAK) ? MAX_DSTREAK : m_streak + 1) : 0;
      end else begin
        m_owner = 1; m_addr = IAddr_i; m_we = 0; m_wdata = 0;
        m_streak = 0;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // compare process
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("mem_req", 32'(MemReq_o), 32'(m_owner != 0));
        if (m_owner != 0) begin
          chk("mem_we", 32'(MemWe_o), 32'(m_we));
          chk("mem_addr", MemAddr_o, m_addr);
          chk("mem_wdata", MemWdata_o, m_wdata);
        end
        chk("ivalid", 32'(IValid_o), 32'(m_ivalid));
        chk("dvalid", 32'(DValid_o), 32'(m_dvalid));
        chk("irdata", IRdata_o, m_irdata);
        chk("drdata", DRdata_o, m_drdata);
        chk("err_timeout", 32'(ErrTimeout_o), 32'(m_err));
        chk("stall_f", 32'(StallF_o), 32'(IReq_i & ~m_ivalid));
        chk("stall_m", 32'(StallM_o), 32'(DReq_i & ~m_dvalid));
        if (m_ivalid) $display("txn fetch  done rdata=%h err=%0d t=%0t", IRdata_o, ErrTimeout_o, $time);
        if (m_dvalid) $display("txn data   done rdata=%h err=%0d t=%0t", DRdata_o, ErrTimeout_o, $time);
      end
    end
  end

  // memory responder: acks ack_delay cycles after MemReq_o rises, never if negative
  initial begin
    int seen;
    seen = 0;
    MemAck_i = 1'b0;
    MemRdata_i = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      #2;
      if (stray_ack) begin
        MemAck_i = 1'b1; MemRdata_i = 32'hBAD0_BAD0; seen = 0;
      end else if (MemReq_o) begin
        if (ack_delay >= 0 && seen == ack_delay) begin
          MemAck_i = 1'b1; MemRdata_i = rdata_for(MemAddr_o);
        end else begin
          MemAck_i = 1'b0; MemRdata_i = 32'hFFFF_FFFF;
        end
        seen++;
      end else begin
        MemAck_i = 1'b0; MemRdata_i = 32'hFFFF_FFFF; seen = 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit want_i, input int limit, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (want_i ? IValid_o : DValid_o) return;
      if (n >= limit) begin
        bound_expired(want_i ? "wait_ivalid" : "wait_dvalid");
        return;
      end
    end
  endtask

  initial begin
    #200000;
    bound_expired("watchdog");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    int  n, c, stall_cnt, nd, ng;
    bit  got, prev_req;
    rst_n = 1'b0;
    IReq_i = 0; DReq_i = 0; DWe_i = 0;
    IAddr_i = 0; DAddr_i = 0; DWdata_i = 0;

    // reset state
    step();
    chk("rst_mem_req", 32'(MemReq_o), 0);
    chk("rst_mem_addr", MemAddr_o, 0);
    chk("rst_ivalid", 32'(IValid_o), 0);
    chk("rst_drdata", DRdata_o, 0);
    chk("rst_err", 32'(ErrTimeout_o), 0);
    rst_n = 1'b1;
    step();

    // fetch only, ack two cycles after MemReq_o
    IReq_i = 1; IAddr_i = 32'h100; ack_delay = 2;
    n = 0; stall_cnt = 0; got = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (IValid_o) got = 1;
      else if (StallF_o) stall_cnt++;
    end
    if (!got) bound_expired("fetch_valid");
    chk("fetch_latency", n, 4);
    chk("fetch_rdata", IRdata_o, 32'h00500093);
    chk("fetch_stall_cycles", stall_cnt, 3);
    chk("stall_f_at_valid", 32'(StallF_o), 0);
    #1 IReq_i = 0;

    // simultaneous requests: data write first, then fetch
    step();
    IReq_i = 1; IAddr_i = 32'h300;
    DReq_i = 1; DWe_i = 1; DAddr_i = 32'h2000; DWdata_i = 32'hDEADBEEF; ack_delay = 1;
    @(negedge clk);
    chk("tie_mem_req", 32'(MemReq_o), 1);
    chk("tie_mem_we", 32'(MemWe_o), 1);
    chk("tie_mem_addr", MemAddr_o, 32'h2000);
    chk("tie_mem_wdata", MemWdata_o, 32'hDEADBEEF);
    wait_valid(1'b0, 20, n);
    chk("write_drdata", DRdata_o, 32'h2000DFFF);
    #1 DReq_i = 0; DWe_i = 0;
    n = 0;
    while (!MemReq_o && n < 20) begin @(negedge clk); n++; end
    chk("fetch_after_write_gap", n, 2);
    chk("fetch_after_write_addr", MemAddr_o, 32'h300);
    wait_valid(1'b1, 20, n);
    chk("fetch_after_write_rdata", IRdata_o, 32'h0300FCFF);
    #1 IReq_i = 0;

    // fetch held while data keeps requesting: four data grants then the fetch
    step();
    IReq_i = 1; IAddr_i = 32'h400;
    DReq_i = 1; DWe_i = 0; DAddr_i = 32'h500;
    nd = 0; ng = 0; got = 0; prev_req = 0; c = 0;
    while (!got && c < 400) begin
      @(negedge clk);
      c++;
      if (MemReq_o && !prev_req) begin
        ng++;
        if (MemAddr_o != 32'h400 && ng <= 5) nd++;
      end
      prev_req = MemReq_o;
      if (IValid_o) begin got = 1; #1 IReq_i = 0; DReq_i = 0; end
    end
    if (!got) bound_expired("streak_fetch_valid");
    chk("streak_d_grants", nd, 4);
    chk("streak_total_grants", ng, 5);

    // streak cleared by the fetch grant: a tie goes to data again
    step();
    IReq_i = 1; IAddr_i = 32'h700;
    DReq_i = 1; DAddr_i = 32'h800;
    @(negedge clk);
    chk("streak_cleared_d_first", MemAddr_o, 32'h800);
    wait_valid(1'b0, 20, n);
    #1 DReq_i = 0;
    wait_valid(1'b1, 20, n);
    #1 IReq_i = 0;

    // no ack: abort after TIMEOUT busy cycles
    step();
    ack_delay = -1;
    DReq_i = 1; DWe_i = 0; DAddr_i = 32'h900;
    n = 0; got = 0; c = 0;
    while (!got && c < 60) begin
      @(negedge clk);
      c++;
      if (DValid_o) got = 1;
      else if (MemReq_o) n++;
    end
    if (!got) bound_expired("timeout_valid");
    chk("timeout_busy_cycles", n, 15);
    chk("timeout_drdata", DRdata_o, 0);
    chk("timeout_err", 32'(ErrTimeout_o), 1);
    chk("timeout_mem_req", 32'(MemReq_o), 0);
    #1 DReq_i = 0;

    // one-cycle-ack fetch; error remains sticky
    ack_delay = 0;
    step();
    IReq_i = 1; IAddr_i = 32'h104;
    wait_valid(1'b1, 20, n);
    chk("fetch_1cyc_latency", n, 2);
    chk("fetch_1cyc_rdata", IRdata_o, 32'h0104FEFB);
    chk("err_sticky", 32'(ErrTimeout_o), 1);
    #1 IReq_i = 0;

    // reset during a data transaction
    ack_delay = -1;
    step();
    DReq_i = 1; DWe_i = 1; DAddr_i = 32'hA00; DWdata_i = 32'h1234;
    @(negedge clk);
    chk("pre_reset_mem_req", 32'(MemReq_o), 1);
    step();
    rst_n = 1'b0; DReq_i = 0; DWe_i = 0;
    #1;
    chk("reset_mem_req_now", 32'(MemReq_o), 0);
    chk("reset_mem_we_now", 32'(MemWe_o), 0);
    chk("reset_mem_addr_now", MemAddr_o, 0);
    chk("reset_err_now", 32'(ErrTimeout_o), 0);
    step();
    rst_n = 1'b1;
    step();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stray_ack_dvalid", 32'(DValid_o), 0);
      chk("stray_ack_drdata", DRdata_o, 0);
    end

    // first grant right after reset release
    step();
    rst_n = 1'b0; IReq_i = 1; IAddr_i = 32'h108; ack_delay = 0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("grant_after_release", 32'(MemReq_o), 1);
    chk("grant_after_release_addr", MemAddr_o, 32'h108);
    wait_valid(1'b1, 20, n);
    #1 IReq_i = 0;

    // request dropped mid-transaction still completes
    step();
    ack_delay = 3; IReq_i = 1; IAddr_i = 32'h10C;
    @(negedge clk);
    #1 IReq_i = 0;
    wait_valid(1'b1, 20, n);
    chk("dropped_req_rdata", IRdata_o, 32'h010CFEF3);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
